fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch front-end inside core. Generates the sequential PC, issues requests on the fetch_addr valid/ready channel, and accepts in-order responses from the 1-cycle instruction SRAM. Buffers instructions in a small FIFO toward decode with a valid/ready handshake. Handles redirects from execute by flushing the buffer and discarding in-flight responses.

Parameters:
XLEN, C::XLEN, address/PC width
RESET_PC, 64'h8000_0000 (truncated to XLEN), PC after reset
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max accepted requests without a response (>=1)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
redirect_valid_i  in  1  redirect request from execute
redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored
fetch_addr_valid  out  1  request valid
fetch_addr_ready  in  1  memory accepts request
fetch_addr  out  XLEN  request address, word aligned
fetch_data_valid  in  1  response valid, in request order
fetch_data  in  32  response instruction
fetch_data_ready  out  1  unit accepts response
instr_valid_o  out  1  instruction valid to decode
instr_o  out  32  instruction
instr_pc_o  out  XLEN  PC of instr_o
instr_ready_i  in  1  decode accepts instruction

Behaviour:
- Reset: rstn sampled at posedge clk; synchronous, active-low. Reset in any state, including mid-operation, returns all state to reset values in one cycle. After reset: fetch_addr_valid=0, fetch_addr=RESET_PC, fetch_data_ready=0, instr_valid_o=0, FIFO empty, outstanding=0, drop_cnt=0, resp_pc=RESET_PC.
- fetch_data_ready=1 in every non-reset cycle. Credits guarantee FIFO space, so a response is never refused.
- Issue condition: fetch_addr_valid = !reset_cycle && outstanding < MAX_OUTSTANDING && fifo_count + outstanding < FIFO_DEPTH.
- fetch_addr_valid depends only on registered state, never on redirect_valid_i or fetch_addr_ready.
- fetch_addr = pc register. pc and fetch_addr are held stable while valid && !ready.
- Accept = fetch_addr_valid && fetch_addr_ready. On accept: pc <= pc+4, wrapping modulo 2^XLEN.
- outstanding_next = outstanding + accept - fetch_data_valid. A response with outstanding=0 is a protocol error; the bench asserts on it.
- Response handling:
  - if drop_cnt>0, the response is discarded and drop_cnt decrements;
  - otherwise {fetch_data, resp_pc} is pushed to the FIFO and resp_pc <= resp_pc+4.
- Redirect (redirect_valid_i=1) has priority over all other same-cycle updates:
  - pc <= {redirect_pc_i[XLEN-1:2],2'b00}; resp_pc <= same value;
  - FIFO flushed, including any same-cycle push and pop; instr_valid_o=0 next cycle;
  - drop_cnt <= outstanding_next. This includes a request accepted in the redirect cycle (old pc) and excludes a response arriving in that cycle, which is itself dropped.
  - Redirect while drop_cnt>0: drop_cnt <= outstanding_next (new value replaces the old one).
  - Back-to-back redirects: the last one wins.
- FIFO: push and pop allowed in the same cycle when full or empty, per the full/empty rules below.
  - instr_valid_o = !empty; instr_o/instr_pc_o = head entry.
  - Pop = instr_valid_o && instr_ready_i.
  - Push when full cannot occur by credit; the bench asserts on it.
  - Head outputs are stable while valid && !ready.
- Latency without the optional feature: request accepted at cycle N; with a 1-cycle SRAM, response at N+1; instr_valid_o at N+2.
- Throughput: 1 instruction/cycle sustained when MAX_OUTSTANDING>=2 and decode is always ready.

Optional Feature:
FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and a non-dropped response arrives, instr_valid_o/instr_o/instr_pc_o are driven combinationally from fetch_data/resp_pc in the same cycle.
  - If instr_ready_i=1 the entry is consumed and not written to the FIFO.
  - Otherwise it is pushed and presented from the FIFO next cycle.
  - Redirect in the same cycle suppresses the bypass (instr_valid_o=0).
  - Latency: instr_valid_o at N+1.
- Undefined: outputs come from the FIFO only; latency N+2.

Test Plan:
- Release reset, fetch_addr_ready=1, 1-cycle SRAM model, instr_ready_i=1 -> fetch_addr 0x8000_0000, 0x8000_0004, ... on consecutive cycles; instr_pc_o sequence identical; one instruction per cycle from the third cycle after reset release.
- Hold instr_ready_i=0 -> exactly 4 entries are buffered and fetch_addr_valid drops to 0; release ready -> PCs 0x8000_0000..0x8000_000C are delivered with none lost or duplicated, then fetch resumes at 0x8000_0010.
- Hold fetch_addr_ready=0 for 3 cycles with valid=1 -> fetch_addr stays at 0x8000_0008 throughout; no response is expected.
- Redirect to 0x8000_1002 with 2 requests in flight -> both responses dropped, FIFO empty; next fetch_addr=0x8000_1000 and first instr_pc_o=0x8000_1000.
- Redirect in the same cycle as an accept and a response -> the response is dropped, drop_cnt=outstanding_next (here 1), and the next delivered PC is the target.
- rstn=0 for 1 cycle mid-stream with a full FIFO -> next cycle instr_valid_o=0, fetch_addr=0x8000_0000, and a stale SRAM response is not pushed. With FETCH_BYPASS_EN, re-run scenario 1 -> first instr_valid_o one cycle earlier.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: sequential PC, credit-limited request issue, in-order SRAM responses buffered toward decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_unit #(
  parameter int          XLEN            = 32,
  parameter logic [63:0] RESET_PC        = 64'h8000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fetch_addr_valid,
  input  logic            fetch_addr_ready,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_data_valid,
  input  logic [31:0]     fetch_data,
  output logic            fetch_data_ready,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
  localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] respPc_q, respPc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   dropCnt_q, dropCnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [31:0]     memData_q [FIFO_DEPTH];
  logic [XLEN-1:0] memPc_q   [FIFO_DEPTH];

  logic            accept;
  logic            respValid;
  logic            respKeep;
  logic            fifoEmpty;
  logic            push;
  logic            pop;
  logic [CW-1:0]   outstandingNext;
  logic [XLEN-1:0] redirectTarget;
  logic            unusedRedirectLow;

  assign unusedRedirectLow = ^redirect_pc_i[1:0];
  assign redirectTarget    = {redirect_pc_i[XLEN-1:2], 2'b00};

  // Request credits cover both in-flight responses and buffered entries, so a response always has a slot.
  assign fetch_data_ready = rstn;
  assign fetch_addr       = pc_q;
  assign fetch_addr_valid = rstn && (outstanding_q < CW'(MAX_OUTSTANDING))
                            && ((count_q + outstanding_q) < CW'(FIFO_DEPTH));
  assign accept           = fetch_addr_valid && fetch_addr_ready;
  assign respValid        = rstn && fetch_data_valid;
  assign respKeep         = respValid && (dropCnt_q == '0) && !redirect_valid_i;
  assign outstandingNext  = outstanding_q + CW'(accept) - CW'(respValid);
  assign fifoEmpty        = (count_q == '0);
  assign pop              = !fifoEmpty && instr_ready_i;

`ifdef FETCH_BYPASS_EN
  logic bypassHit;
  assign bypassHit     = fifoEmpty && respKeep;
  assign instr_valid_o = !fifoEmpty || bypassHit;
  assign instr_o       = fifoEmpty ? fetch_data : memData_q[rdPtr_q];
  assign instr_pc_o    = fifoEmpty ? respPc_q : memPc_q[rdPtr_q];
  assign push          = respKeep && !(bypassHit && instr_ready_i);
`else
  assign instr_valid_o = !fifoEmpty;
  assign instr_o       = memData_q[rdPtr_q];
  assign instr_pc_o    = memPc_q[rdPtr_q];
  assign push          = respKeep;
`endif

  // Redirect overrides every other update: new PC, empty buffer, and drop whatever is still in flight.
  always_comb begin
    pc_d          = pc_q;
    respPc_d      = respPc_q;
    outstanding_d = outstandingNext;
    dropCnt_d     = dropCnt_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    rdPtr_d       = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    wrPtr_d       = push ? wrPtr_q + PW'(1) : wrPtr_q;
    if (accept) pc_d = pc_q + XLEN'(4);
    if (respKeep) respPc_d = respPc_q + XLEN'(4);
    if (respValid && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - CW'(1);
    if (redirect_valid_i) begin
      pc_d      = redirectTarget;
      respPc_d  = redirectTarget;
      dropCnt_d = outstandingNext;
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q          <= START_PC;
      respPc_q      <= START_PC;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
      count_q       <= '0;
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      respPc_q      <= respPc_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
      count_q       <= count_d;
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      memData_q[wrPtr_q] <= fetch_data;
      memPc_q[wrPtr_q]   <= respPc_q;
    end
  end

endmodule
